// File: rtl/mem_arbiter_if.sv
// Request/grant, read-return and memory-macro signals of the unified-memory arbiter.
// slave = arbiter side, master = core and memory-macro side.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_ce;
   logic              mem_wre;
   logic [ADDR_W-1:0] mem_ad;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_ce, mem_wre, mem_ad, mem_din
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_ce, mem_wre, mem_ad, mem_din
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port 1-cycle-latency memory between fetch and load/store ports.
// Optional ARB_PERF_EN adds perf_conflicts / perf_istall event counters.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_arbiter_if.slave bus
`ifdef ARB_PERF_EN
   ,
   output logic [31:0] perf_conflicts,
   output logic [31:0] perf_istall
`endif
);
   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;
   logic             i_win;
   logic             i_gnt;
   logic             d_gnt;

   // Fetch wins when uncontested or once it has been starved MAX_WAIT cycles.
   always_comb begin
      i_win = bus.i_req & (~bus.d_req | (wait_cnt == WAIT_LIM));
      i_gnt = rst_n & i_win;
      d_gnt = rst_n & bus.d_req & ~i_win;
   end

   always_comb begin
      bus.i_gnt   = i_gnt;
      bus.d_gnt   = d_gnt;
      bus.mem_ce  = i_gnt | d_gnt;
      bus.mem_wre = d_gnt & bus.d_we;
      bus.mem_ad  = i_gnt ? bus.i_addr : bus.d_addr;
      bus.mem_din = bus.d_wdata;
      bus.i_rdata = bus.mem_dout;
      bus.d_rdata = bus.mem_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!bus.i_req || i_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIM) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_rvalid <= 1'b0;
         bus.d_rvalid <= 1'b0;
      end else begin
         bus.i_rvalid <= i_gnt;
         bus.d_rvalid <= d_gnt & ~bus.d_we;
      end
   end

`ifdef ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflicts <= '0;
         perf_istall    <= '0;
      end else begin
         if (bus.i_req && bus.d_req) perf_conflicts <= perf_conflicts + 32'd1;
         if (bus.i_req && !i_gnt)    perf_istall    <= perf_istall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model with a shadow memory.
module tb_mem_arbiter;
   localparam int unsigned ADDR_W   = 11;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_WAIT = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_EN
   logic [31:0] perf_conflicts;
   logic [31:0] perf_istall;
`endif

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus)
`ifdef ARB_PERF_EN
      ,
      .perf_conflicts (perf_conflicts),
      .perf_istall    (perf_istall)
`endif
   );

   // Memory macro: 1-cycle read latency, preload port used only while in reset.
   logic [DATA_W-1:0] macro_mem [0:(1<<ADDR_W)-1];
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;
   always @(posedge clk) begin
      if (pl_en) macro_mem[pl_addr] <= pl_data;
      else if (bus.mem_ce) begin
         if (bus.mem_wre) macro_mem[bus.mem_ad] <= bus.mem_din;
         else             bus.mem_dout <= macro_mem[bus.mem_ad];
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
   int                streak;
   logic              exp_irv, exp_drv, last_igot, last_dgot;
   logic [DATA_W-1:0] exp_idata, exp_ddata;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      streak    = 0;
      exp_irv   = 1'b0;
      exp_drv   = 1'b0;
      last_igot = 1'b0;
      last_dgot = 1'b0;
   endtask

   // One clock cycle: drive at negedge, compare 1 time unit later, advance the model.
   task automatic cycle(input logic ireq, input logic [ADDR_W-1:0] iaddr,
                        input logic dreq, input logic dwe,
                        input logic [ADDR_W-1:0] daddr, input logic [DATA_W-1:0] wd);
      logic ei, ed;
      @(negedge clk);
      bus.i_req = ireq; bus.i_addr = iaddr;
      bus.d_req = dreq; bus.d_we = dwe; bus.d_addr = daddr; bus.d_wdata = wd;
      #1;
      ei = ireq && (!dreq || streak >= int'(MAX_WAIT));
      ed = dreq && !ei;
      check("i_gnt", bus.i_gnt, ei);
      check("d_gnt", bus.d_gnt, ed);
      check("mem_ce", bus.mem_ce, ei | ed);
      check("mem_wre", bus.mem_wre, ed & dwe);
      if (ei | ed) check("mem_ad", bus.mem_ad, ei ? iaddr : daddr);
      if (ed & dwe) check("mem_din", bus.mem_din, wd);
      check("i_rvalid", bus.i_rvalid, exp_irv);
      check("d_rvalid", bus.d_rvalid, exp_drv);
      if (exp_irv) check("i_rdata", bus.i_rdata, exp_idata);
      if (exp_drv) check("d_rdata", bus.d_rdata, exp_ddata);
      streak    = (ireq && !ei) ? streak + 1 : 0;
      exp_irv   = ei;
      exp_idata = ref_mem[iaddr];
      exp_drv   = ed && !dwe;
      exp_ddata = ref_mem[daddr];
      if (ed && dwe) ref_mem[daddr] = wd;
      last_igot = ei;
      last_dgot = ed;
   endtask

   task automatic idle();
      cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   typedef struct {
      logic ireq, dreq, dwe;
      logic ei, ed, ce, wre;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [6];
      logic r_ireq, r_dreq, r_dwe;
      logic [ADDR_W-1:0] r_iaddr, r_daddr;
      logic [DATA_W-1:0] r_wd;
      logic expi;
`ifdef ARB_PERF_EN
      logic [31:0] pc0, ps0;
`endif
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset with both requests up: grants and memory enables must stay low.
      rst_n = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      bus.i_req = 1'b1; bus.i_addr = '0;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = '0; bus.d_wdata = '0;
      for (int a = 0; a < 64; a++) begin
         @(negedge clk);
         pl_en   = 1'b1;
         pl_addr = ADDR_W'(a);
         pl_data = (a == 5) ? 32'h00500113 : $urandom;
         ref_mem[a] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;
      #1;
      check("rst_i_gnt", bus.i_gnt, 0);
      check("rst_d_gnt", bus.d_gnt, 0);
      check("rst_mem_ce", bus.mem_ce, 0);
      check("rst_mem_wre", bus.mem_wre, 0);
      check("rst_i_rvalid", bus.i_rvalid, 0);
      check("rst_d_rvalid", bus.d_rvalid, 0);
      @(negedge clk);
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      rst_n = 1'b1;
      model_reset();

      // Fetch from word 5
      cycle(1'b1, 11'd5, 1'b0, 1'b0, '0, '0);
      check("fetch_gnt", bus.i_gnt, 1);
      idle();
      check("fetch_rvalid", bus.i_rvalid, 1);
      check("fetch_rdata", bus.i_rdata, 32'h00500113);

      // Store then load back
      cycle(1'b0, '0, 1'b1, 1'b1, 11'd3, 32'hDEADBEEF);
      check("store_wre", bus.mem_wre, 1);
      check("store_ad", bus.mem_ad, 3);
      cycle(1'b0, '0, 1'b1, 1'b0, 11'd3, '0);
      check("store_no_rvalid", bus.d_rvalid, 0);
      idle();
      check("load_rvalid", bus.d_rvalid, 1);
      check("load_rdata", bus.d_rdata, 32'hDEADBEEF);

      // Vector table, each entry followed by an idle cycle
      for (int v = 0; v < 6; v++) begin
         cycle(vecs[v].ireq, ADDR_W'($urandom_range(0, 63)), vecs[v].dreq, vecs[v].dwe,
               ADDR_W'($urandom_range(0, 63)), $urandom);
         check("vec_i_gnt", bus.i_gnt, vecs[v].ei);
         check("vec_d_gnt", bus.d_gnt, vecs[v].ed);
         check("vec_mem_ce", bus.mem_ce, vecs[v].ce);
         check("vec_mem_wre", bus.mem_wre, vecs[v].wre);
         idle();
      end

      // Sustained conflict: fetch wins on cycles 4 and 9
`ifdef ARB_PERF_EN
      @(negedge clk); #1;
      pc0 = perf_conflicts; ps0 = perf_istall;
`endif
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 11'd7, 1'b1, 1'b0, 11'd9, '0);
         expi = (k == 4) || (k == 9);
         check("conf_i_gnt", bus.i_gnt, expi);
         check("conf_d_gnt", bus.d_gnt, !expi);
         check("conf_overlap", bus.i_gnt & bus.d_gnt, 0);
      end
      idle();
`ifdef ARB_PERF_EN
      check("perf_conflicts", perf_conflicts - pc0, 10);
      check("perf_istall", perf_istall - ps0, 8);
`endif
      idle();

      // Alternating i, d, i reads
      cycle(1'b1, 11'd10, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, '0, 1'b1, 1'b0, 11'd11, '0);
      check("alt1_i_rvalid", bus.i_rvalid, 1);
      check("alt1_d_rvalid", bus.d_rvalid, 0);
      cycle(1'b1, 11'd12, 1'b0, 1'b0, '0, '0);
      check("alt2_i_rvalid", bus.i_rvalid, 0);
      check("alt2_d_rvalid", bus.d_rvalid, 1);
      idle();
      check("alt3_i_rvalid", bus.i_rvalid, 1);
      check("alt3_d_rvalid", bus.d_rvalid, 0);
      idle();

      // Load granted, then reset before the edge that would register it
      @(negedge clk);
      bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'd20;
      #1;
      check("rstmid_gnt", bus.d_gnt, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_forced_gnt", bus.d_gnt, 0);
      @(negedge clk);
      bus.d_req = 1'b0;
      check("rstmid_rvalid_in_reset", bus.d_rvalid, 0);
      rst_n = 1'b1;
      model_reset();
      idle();
      check("rstmid_rvalid_after", bus.d_rvalid, 0);
      idle();

      // Randomized traffic obeying the hold-until-granted rule
      r_ireq = 1'b0; r_dreq = 1'b0; r_dwe = 1'b0;
      r_iaddr = '0; r_daddr = '0; r_wd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!r_ireq || last_igot || $urandom_range(0, 19) == 0) begin
            r_ireq  = ($urandom_range(0, 2) != 0);
            r_iaddr = ADDR_W'($urandom_range(0, 63));
         end
         if (!r_dreq || last_dgot || $urandom_range(0, 19) == 0) begin
            r_dreq  = ($urandom_range(0, 2) != 0);
            r_dwe   = ($urandom_range(0, 2) == 0);
            r_daddr = ADDR_W'($urandom_range(0, 63));
            r_wd    = $urandom;
         end
         cycle(r_ireq, r_iaddr, r_dreq, r_dwe, r_daddr, r_wd);
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory (BSRAM-style, 1-cycle read latency, output register bypassed) between the core's instruction-fetch port and its data load/store port.
- Decides which requester owns the memory each cycle and drives the macro's ce/wre/ad/din.
- Routes returned read data back to the requester that issued it, with a per-port read-valid strobe.
- Enables a unified instruction/data memory in place of separate instruction and data memories.

Parameters:
ADDR_W, 11, word address width driven to the memory macro
DATA_W, 32, data word width
MAX_WAIT, 4, consecutive denied cycles after which the instruction port wins a conflict; 0 = instruction port always wins

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  instruction fetch request, held until granted
i_addr  input  ADDR_W  fetch word address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid on i_rdata (registered)
i_rdata  output  DATA_W  fetch data
d_req  input  1  data access request, held until granted
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data word address
d_wdata  input  DATA_W  store data
d_gnt  output  1  data access accepted this cycle (combinational)
d_rvalid  output  1  load data valid on d_rdata (registered)
d_rdata  output  DATA_W  load data
mem_ce  output  1  memory clock enable
mem_wre  output  1  memory write enable
mem_ad  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_dout  input  DATA_W  memory read data, valid one cycle after a read is issued

Behaviour:
- Reset (rst_n low, asynchronous): i_rvalid=0, d_rvalid=0, wait counter=0. Grants, mem_ce and mem_wre are forced to 0 while rst_n is low.
- At most one grant per cycle.
- Single request: it is granted in the same cycle.
- Conflict (i_req & d_req):
  - d wins while wait_cnt < MAX_WAIT.
  - i wins when wait_cnt == MAX_WAIT.
- wait_cnt:
  - +1 each cycle i_req & !i_gnt, saturating at MAX_WAIT.
  - Cleared on i_gnt or !i_req.
- Memory drive:
  - mem_ce = i_gnt | d_gnt.
  - mem_wre = d_gnt & d_we.
  - mem_ad / mem_din come from the granted port; d_addr / d_wdata when idle (don't-care).
- Read return:
  - The owner of an issued read is registered: i_rvalid <= i_gnt; d_rvalid <= d_gnt & !d_we.
  - i_rdata = d_rdata = mem_dout; each is meaningful only with its rvalid.
  - Latency is grant + 1 cycle.
- Stores produce no rvalid.
- Back-to-back grants to alternating ports are legal every cycle. Each rvalid tracks its own issue cycle.
- A requester must hold req, address and data stable until its gnt. A request dropped before gnt is simply not serviced.
- Reset asserted mid-operation: a pending rvalid is discarded (cleared asynchronously) and never appears after release.

Optional Feature:
ARB_PERF_EN
- Defined:
  - Adds outputs perf_conflicts (32 bits) and perf_istall (32 bits), both cleared on reset.
  - perf_conflicts increments each cycle i_req & d_req.
  - perf_istall increments each cycle i_req & !i_gnt.
  - Both wrap at 2^32 to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset → all outputs 0. Release rst_n; i_req=1, i_addr=5, memory word 5 = 32'h00500113 → i_gnt same cycle, next cycle i_rvalid=1, i_rdata=32'h00500113.
- d_req=1, d_we=1, d_addr=3, d_wdata=32'hDEADBEEF → mem_wre=1, mem_ad=3, no d_rvalid. Then a load from address 3 → d_rvalid one cycle later with 32'hDEADBEEF.
- MAX_WAIT=4, i_req and d_req both held high continuously:
  - d granted in cycles 0..3, i granted in cycle 4, d in cycles 5..8, i in cycle 9.
  - Grants never overlap.
- Alternating grants i, d, i with reads → rvalid pulses follow the same order one cycle later, each on the correct port.
- Grant a load, then pull rst_n low before the next edge → d_rvalid stays 0 after reset release.
- With ARB_PERF_EN, 10 conflict cycles with MAX_WAIT=4 → perf_conflicts=10, perf_istall=8.
